// File: rtl/sram_model_param.sv
// Cycle-accurate model of the board SRAM: byte lanes, CE/OE/WE gating, pipelined reads and a post-reset init sweep.
// Build option: define SRAM_MODEL_INIT_PATTERN_EN to make the sweep write mem[i] = i instead of zero.
module sram_model_param #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 18,
    parameter int DEPTH        = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    inout  wire  [DATA_WIDTH-1:0]   SRAM_DQ,
    input  logic [ADDR_WIDTH-1:0]   SRAM_ADDR,
    input  logic [DATA_WIDTH/8-1:0] SRAM_BE_N,
    input  logic                    SRAM_WE_N,
    input  logic                    SRAM_CE_N,
    input  logic                    SRAM_OE_N,
    output logic                    init_done
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]      idx;
    logic                  wr_req;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] init_word;
    logic [DATA_WIDTH-1:0] dq_out;
    logic [NB-1:0]         dq_oe;

    // Bus strobes are sampled every rising edge (no handshake): CE_N=0 & WE_N=0 is a write,
    // CE_N=0 & WE_N=1 & OE_N=0 is a read request; the bus is only honoured in READY.
    assign idx       = SRAM_ADDR[IDX_W-1:0];
    assign wr_req    = (state_q == ST_READY) && !SRAM_CE_N && !SRAM_WE_N;
    assign rd_req    = (state_q == ST_READY) && !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
    assign init_done = init_done_q;

    if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^SRAM_ADDR[ADDR_WIDTH-1:IDX_W];
    end

`ifdef SRAM_MODEL_INIT_PATTERN_EN
    assign init_word = DATA_WIDTH'(cnt_q);
`else
    assign init_word = '0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d     = ST_READY;
                init_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // The reset edge never touches the array; the sweep starts on the first edge after it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_q[cnt_q] <= init_word;
            end else if (wr_req) begin
                for (int b = 0; b < NB; b++) begin
                    if (!SRAM_BE_N[b]) begin
                        mem_q[idx][8*b +: 8] <= SRAM_DQ[8*b +: 8];
                    end
                end
            end
        end
    end

    if (READ_LATENCY == 0) begin : g_comb_read
        always_comb begin
            dq_out = mem_q[idx];
            dq_oe  = '0;
            for (int b = 0; b < NB; b++) begin
                dq_oe[b] = rd_req & ~SRAM_BE_N[b];
            end
        end
    end else begin : g_pipe_read
        logic [READ_LATENCY-1:0] vld_q;
        logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];
        logic [NB-1:0]           be_n_q [READ_LATENCY];

        // Data is snapshotted at request time, so later writes cannot alter an in-flight read.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
            end else begin
                vld_q[0]  <= rd_req;
                data_q[0] <= mem_q[idx];
                be_n_q[0] <= SRAM_BE_N;
                for (int s = 1; s < READ_LATENCY; s++) begin
                    vld_q[s]  <= vld_q[s-1];
                    data_q[s] <= data_q[s-1];
                    be_n_q[s] <= be_n_q[s-1];
                end
            end
        end

        always_comb begin
            dq_out = data_q[READ_LATENCY-1];
            dq_oe  = '0;
            for (int b = 0; b < NB; b++) begin
                dq_oe[b] = vld_q[READ_LATENCY-1] & SRAM_WE_N & ~be_n_q[READ_LATENCY-1][b];
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_lane
        assign SRAM_DQ[8*b +: 8] = dq_oe[b] ? dq_out[8*b +: 8] : 8'bz;
    end

endmodule

// File: tb/tb_sram_model_param.sv
// Directed and randomised bench for sram_model_param: a reference memory model feeds a read scoreboard
// that a negedge monitor checks against the bus (pulled high, so an undriven lane reads 0xFF).
module tb_sram_model_param;
    localparam int DW    = 16;
    localparam int AW    = 18;
    localparam int DEPTH = 64;
    localparam int LAT   = 2;
    localparam int NB    = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] sram_addr;
    logic [NB-1:0] sram_be_n;
    logic          sram_we_n;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic [DW-1:0] tb_dq;
    logic          tb_dq_en;
    wire  [DW-1:0] sram_dq;
    wire           init_done;

    for (genvar gi = 0; gi < DW; gi++) begin : g_pu
        pullup (sram_dq[gi]);
    end
    assign sram_dq = tb_dq_en ? tb_dq : 'z;

    sram_model_param #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .DEPTH       (DEPTH),
        .READ_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SRAM_DQ  (sram_dq),
        .SRAM_ADDR(sram_addr),
        .SRAM_BE_N(sram_be_n),
        .SRAM_WE_N(sram_we_n),
        .SRAM_CE_N(sram_ce_n),
        .SRAM_OE_N(sram_oe_n),
        .init_done(init_done)
    );

    // Clock and reset-time defaults
    always #5 clk = ~clk;

    logic [DW-1:0] ref_mem [DEPTH];
    logic          ref_ready     = 1'b0;
    logic          ref_init_done = 1'b0;
    int            ref_cnt       = 0;
    int            cyc           = 0;

    logic [DW-1:0] exp_q[$];
    logic [NB-1:0] exp_be_q[$];
    int            exp_due_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference behaviour for one rising edge, using the inputs held during cycle cyc.
    task automatic model_edge();
        int idx;
        idx = int'(sram_addr) % DEPTH;
        if (rst) begin
            ref_ready     = 1'b0;
            ref_init_done = 1'b0;
            ref_cnt       = 0;
            exp_q.delete();
            exp_be_q.delete();
            exp_due_q.delete();
        end else if (!ref_ready) begin
`ifdef SRAM_MODEL_INIT_PATTERN_EN
            ref_mem[ref_cnt] = DW'(ref_cnt);
`else
            ref_mem[ref_cnt] = '0;
`endif
            if (ref_cnt == DEPTH - 1) begin
                ref_ready     = 1'b1;
                ref_init_done = 1'b1;
            end
            ref_cnt++;
        end else if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < NB; b++) begin
                if (!sram_be_n[b]) ref_mem[idx][8*b +: 8] = tb_dq[8*b +: 8];
            end
        end else if (!sram_ce_n && sram_we_n && !sram_oe_n) begin
            exp_q.push_back(ref_mem[idx]);
            exp_be_q.push_back(sram_be_n);
            exp_due_q.push_back(cyc + LAT);
        end
        cyc++;
    endtask

    // Driver tasks
    task automatic drive(input logic r, input logic ce_n, input logic we_n, input logic oe_n,
                         input logic [NB-1:0] be_n, input int addr, input logic [DW-1:0] data,
                         input logic drv);
        rst       = r;
        sram_ce_n = ce_n;
        sram_we_n = we_n;
        sram_oe_n = oe_n;
        sram_be_n = be_n;
        sram_addr = AW'(addr);
        tb_dq     = data;
        tb_dq_en  = drv;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, '1, 0, '0, 1'b0);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, '1, 0, '0, 1'b0);
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] data, input logic [NB-1:0] be_n);
        drive(1'b0, 1'b0, 1'b0, 1'b1, be_n, addr, data, 1'b1);
    endtask

    task automatic rd(input int addr, input logic [NB-1:0] be_n);
        drive(1'b0, 1'b0, 1'b1, 1'b0, be_n, addr, '0, 1'b0);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = DW'($urandom);
        for (int b = 0; b < NB; b++) begin
            if (w[8*b +: 8] == 8'hFF) w[8*b +: 8] = 8'hFE;
        end
        return w;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [DW-1:0] exp_dq;
        logic [DW-1:0] e_data;
        logic [NB-1:0] e_be;
        exp_dq = tb_dq_en ? tb_dq : '1;
        if (exp_due_q.size() != 0 && exp_due_q[0] == cyc) begin
            e_data = exp_q.pop_front();
            e_be   = exp_be_q.pop_front();
            void'(exp_due_q.pop_front());
            if (sram_we_n) begin
                for (int b = 0; b < NB; b++) begin
                    if (!e_be[b]) exp_dq[8*b +: 8] = e_data[8*b +: 8];
                end
            end
        end
        check("dq", 32'(sram_dq), 32'(exp_dq));
        check("init_done", 32'(init_done), 32'(ref_init_done));
    end

    initial begin
        logic          r, ce_n, we_n, oe_n;
        logic [NB-1:0] be_n;
        int            addr;

        reset_cycles(2);
        idle(DEPTH + 1);

        rd(5, 2'b00);
        idle(LAT + 1);

        wr(3, 16'hABCD, 2'b00);
        wr(3, 16'h1234, 2'b01);
        rd(3, 2'b00);
        idle(LAT + 1);

        wr(70, 16'h5A5A, 2'b00);
        rd(6, 2'b00);
        idle(LAT + 1);

        wr(1, 16'h0011, 2'b00);
        wr(2, 16'h0022, 2'b00);
        wr(3, 16'h0033, 2'b00);
        idle(2);
        rd(1, 2'b00);
        rd(2, 2'b00);
        rd(3, 2'b00);
        idle(LAT + 2);

        // CE_N=1 write must not land; OE_N=1 read must not drive
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1, 16'hDEAD, 1'b1);
        rd(1, 2'b00);
        idle(LAT + 1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2, '0, 1'b0);
        idle(LAT + 2);

        // WE_N low in the output cycle drops the read
        rd(2, 2'b00);
        idle(LAT - 1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 0, '0, 1'b0);
        idle(2);

        rd(3, 2'b10);
        rd(2, 2'b01);
        idle(LAT + 1);

        // Reset one cycle after a read request
        rd(4, 2'b00);
        reset_cycles(1);
        idle(DEPTH + LAT + 2);

        // Reset in the middle of the sweep
        reset_cycles(1);
        idle(40);
        reset_cycles(1);
        idle(DEPTH + 2);

        for (int i = 0; i < 500; i++) begin
            r    = ($urandom_range(0, 249) == 0);
            ce_n = ($urandom_range(0, 5) == 0);
            we_n = 1'($urandom_range(0, 1));
            oe_n = ($urandom_range(0, 5) == 0);
            be_n = NB'($urandom);
            addr = int'($urandom_range(0, 255));
            drive(r, ce_n, we_n, oe_n, be_n, addr, rand_word(), ~we_n);
        end

        idle(LAT + 2);
        @(negedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
